divider_seq_ctrl: RTL and testbench

Sequencing controller for the Goldschmidt divider datapath. Accepts a divide request through a start/busy/done handshake and latches the operands. It then drives the datapath's register enables and mux selects through one initial-approximation pass and `ITERS` refinement passes, ending with a drain cycle, so the quotient register holds the final result when `done` pulses. It sits directly upstream of the divider datapath and owns every control input of that datapath.

---
 rtl/divider_seq_ctrl.sv | 117 +++++++++++
 tb/tb_divider_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath: start/busy/done handshake,
// operand latches and state-decoded enables/selects for the initial and refinement passes.
module divider_seq_ctrl #(
    parameter int unsigned ITERS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] n_in,
    input  logic [15:0] d_in,
    output logic [15:0] N,
    output logic [15:0] D,
    output logic        kSave,
    output logic        nSave,
    output logic        dSave,
    output logic        kNextSel,
    output logic [1:0]  muxSelB,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_N,
        S_INIT_D,
        S_ITER_N,
        S_ITER_D,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;

    assign accept = (state == S_IDLE) && start;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = d_in[15] ? S_INIT_N : S_DONE;
            S_INIT_N: state_nxt = S_INIT_D;
            S_INIT_D: state_nxt = S_ITER_N;
            S_ITER_N: state_nxt = S_ITER_D;
            S_ITER_D: state_nxt = (cnt < LAST_CNT) ? S_ITER_N : S_DRAIN;
            S_DRAIN:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            N        <= '0;
            D        <= '0;
            err      <= 1'b0;
            kSave    <= 1'b0;
            nSave    <= 1'b0;
            dSave    <= 1'b0;
            kNextSel <= 1'b0;
            muxSelB  <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                N   <= n_in;
                D   <= d_in;
                cnt <= '0;
                err <= ~d_in[15];
            end else if (state == S_ITER_D) begin
                cnt <= cnt + 4'd1;
            end

            // Outputs are decoded from the state being entered, so they are
            // registered yet still track the current state exactly.
            kSave    <= 1'b0;
            nSave    <= 1'b0;
            dSave    <= 1'b0;
            kNextSel <= 1'b0;
            muxSelB  <= 2'b00;
            done     <= 1'b0;
            busy     <= (state_nxt != S_IDLE);
            unique case (state_nxt)
                S_INIT_N: begin
                    kNextSel <= 1'b1;
                    nSave    <= 1'b1;
                end
                S_INIT_D: begin
                    kNextSel <= 1'b1;
                    muxSelB  <= 2'b01;
                    dSave    <= 1'b1;
                    kSave    <= 1'b1;
                end
                S_ITER_N, S_DRAIN: begin
                    muxSelB <= 2'b10;
                    nSave   <= 1'b1;
                end
                S_ITER_D: begin
                    muxSelB <= 2'b11;
                    dSave   <= 1'b1;
                    kSave   <= 1'b1;
                end
                S_DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Bench for divider_seq_ctrl: three instances (ITERS = 3, 1, 15) checked every cycle against
// a position-in-request reference model, plus table vectors and corner-case sequences.
module tb_divider_seq_ctrl;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start [3];
    logic [15:0] n_in  [3];
    logic [15:0] d_in  [3];
    logic [15:0] nq    [3];
    logic [15:0] dq    [3];
    logic        ks    [3];
    logic        ns    [3];
    logic        ds    [3];
    logic        kns   [3];
    logic [1:0]  msb   [3];
    logic        bsy   [3];
    logic        dn    [3];
    logic        er    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        divider_seq_ctrl #(.ITERS((g == 0) ? 3 : (g == 1) ? 1 : 15)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start[g]),
            .n_in     (n_in[g]),
            .d_in     (d_in[g]),
            .N        (nq[g]),
            .D        (dq[g]),
            .kSave    (ks[g]),
            .nSave    (ns[g]),
            .dSave    (ds[g]),
            .kNextSel (kns[g]),
            .muxSelB  (msb[g]),
            .busy     (bsy[g]),
            .done     (dn[g]),
            .err      (er[g])
        );
    end

    // Reference model: mk = edges since acceptance (0 = idle), mem = error-path request.
    int          mk   [3];
    bit          mem  [3];
    logic        merr [3];
    logic [15:0] mn   [3];
    logic [15:0] md   [3];
    int          n_chk  = 0;
    int          n_fail = 0;

    typedef struct {
        int          idx;
        logic [15:0] n;
        logic [15:0] d;
        logic        err;
        int          edges;  // edges from acceptance through entry into DONE
        bit          poke;   // extra start pulses while busy
    } vec_t;

    vec_t vecs [8];

    function automatic int iters_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 15;
    endfunction

    // {kSave,nSave,dSave,kNextSel,muxSelB,busy,done}
    function automatic logic [7:0] obs(input int i);
        return {ks[i], ns[i], ds[i], kns[i], msb[i], bsy[i], dn[i]};
    endfunction

    function automatic logic [7:0] exp_out(input int it, input int k, input bit e);
        if (k == 0) return 8'b0000_0000;
        if (e || k == 2 * it + 4) return 8'b0000_0011;
        if (k == 1) return 8'b0101_0010;
        if (k == 2) return 8'b1011_0110;
        if (((k - 3) % 2) == 0) return 8'b0100_1010;
        return 8'b1010_1110;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                mk[i] = 0; mem[i] = 1'b0; merr[i] = 1'b0; mn[i] = '0; md[i] = '0;
            end else if (mk[i] == 0) begin
                if (start[i]) begin
                    mn[i]   = n_in[i];
                    md[i]   = d_in[i];
                    merr[i] = ~d_in[i][15];
                    mem[i]  = ~d_in[i][15];
                    mk[i]   = 1;
                end
            end else if ((mem[i] && mk[i] == 1) || mk[i] == 2 * iters_of(i) + 4) begin
                mk[i] = 0;
            end else begin
                mk[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("outputs[%0d] step %0d", i, mk[i]), 64'(obs(i)),
                  64'(exp_out(iters_of(i), mk[i], mem[i])));
            check($sformatf("err[%0d]", i), 64'(er[i]), 64'(merr[i]));
            check($sformatf("N/D[%0d]", i), 64'({nq[i], dq[i]}), 64'({mn[i], md[i]}));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_req(input vec_t v);
        int t        = 0;
        int busy_cnt = 0;
        bit seen     = 1'b0;
        n_in[v.idx]  = v.n;
        d_in[v.idx]  = v.d;
        start[v.idx] = 1'b1;
        while (!seen && t < 60) begin
            tick();
            t++;
            start[v.idx] = 1'b0;
            if (v.poke && (t == 3 || t == 6)) begin
                start[v.idx] = 1'b1;
                n_in[v.idx]  = 16'($urandom);
                d_in[v.idx]  = 16'($urandom) | 16'h8000;
            end
            if (bsy[v.idx]) busy_cnt++;
            if (dn[v.idx]) seen = 1'b1;
        end
        check("edges to done", 64'(t), 64'(v.edges));
        check("busy cycles", 64'(busy_cnt), 64'(v.edges));
        check("err flag", 64'(er[v.idx]), 64'(v.err));
        check("N/D latched", 64'({nq[v.idx], dq[v.idx]}), 64'({v.n, v.d}));
        start[v.idx] = 1'b0;
        tick();
        check("done single cycle", 64'(dn[v.idx]), 64'd0);
        check("back to idle", 64'(bsy[v.idx]), 64'd0);
    endtask

    initial begin
        int prev;
        int ndone;

        vecs[0] = '{0, 16'h6000, 16'hA000, 1'b0, 10, 1'b0};
        vecs[1] = '{0, 16'h6000, 16'h4000, 1'b1, 1,  1'b0};
        vecs[2] = '{0, 16'h1234, 16'h0000, 1'b1, 1,  1'b0};
        vecs[3] = '{0, 16'h7FFF, 16'h8000, 1'b0, 10, 1'b1};
        vecs[4] = '{1, 16'h6000, 16'hA000, 1'b0, 6,  1'b0};
        vecs[5] = '{2, 16'h6000, 16'hA000, 1'b0, 34, 1'b0};
        vecs[6] = '{1, 16'hFFFF, 16'hFFFF, 1'b0, 6,  1'b1};
        vecs[7] = '{2, 16'h0001, 16'h7FFF, 1'b1, 1,  1'b0};

        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; n_in[i] = '0; d_in[i] = '0;
            mk[i] = 0; mem[i] = 1'b0; merr[i] = 1'b0; mn[i] = '0; md[i] = '0;
        end

        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset state[%0d]", i), 64'({obs(i), er[i], nq[i], dq[i]}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) run_req(vecs[v]);

        // Asynchronous reset while in ITER_D of the first refinement pass.
        n_in[0] = 16'h6000; d_in[0] = 16'hA000; start[0] = 1'b1;
        repeat (4) begin
            tick();
            start[0] = 1'b0;
        end
        check("in ITER_D before reset", 64'({ds[0], ks[0], msb[0]}), 64'b1111);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("async reset[%0d]", i), 64'({obs(i), er[i], nq[i], dq[i]}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        run_req(vecs[0]);

        // Start held high on the ITERS=1 instance: one result every 7 cycles.
        n_in[1] = 16'h6000; d_in[1] = 16'hA000; start[1] = 1'b1;
        prev  = -1;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (dn[1]) begin
                if (prev >= 0) check("back-to-back period", 64'(c - prev), 64'd7);
                prev = c;
                ndone++;
            end
        end
        check("back-to-back count", 64'(ndone), 64'd5);
        start[1] = 1'b0;
        repeat (8) tick();

        // Random requests, operands and occasional resets on all instances.
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                n_in[i]  = 16'($urandom);
                d_in[i]  = 16'($urandom);
                if ($urandom_range(0, 7) != 0) d_in[i][15] = 1'b1;
            end
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        repeat (40) tick();
        for (int i = 0; i < 3; i++)
            check($sformatf("final idle[%0d]", i), 64'(bsy[i]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
